// File: rtl/dual_issue_dispatch_if.sv
// Signal bundle between decoder, regfile, forwarding network, dispatch and EX.
// slave = dispatch stage, master = surrounding pipeline.
interface dual_issue_dispatch_if #(
  parameter int PAYLOAD_W = 64,
  parameter int FWD_N     = 6
);
  logic                   flush;
  logic [1:0]             in_valid;
  logic                   in_ready;
  logic [63:0]            in_pc;
  logic [2*PAYLOAD_W-1:0] in_payload;
  logic [3:0]             in_src_en;
  logic [19:0]            in_src_addr;
  logic [9:0]             in_rd;
  logic [1:0]             in_rd_we;

  logic [1:0]             reg1_read_en;
  logic [1:0]             reg2_read_en;
  logic [4:0]             reg1_read_addr1;
  logic [4:0]             reg1_read_addr2;
  logic [4:0]             reg2_read_addr1;
  logic [4:0]             reg2_read_addr2;
  logic [31:0]            reg1_read_data1;
  logic [31:0]            reg1_read_data2;
  logic [31:0]            reg2_read_data1;
  logic [31:0]            reg2_read_data2;

  logic [FWD_N-1:0]       fwd_valid;
  logic [5*FWD_N-1:0]     fwd_addr;
  logic [32*FWD_N-1:0]    fwd_data;
  logic [FWD_N-1:0]       fwd_ready;

  logic [1:0]             out_valid;
  logic                   out_ready;
  logic [63:0]            out_pc;
  logic [2*PAYLOAD_W-1:0] out_payload;
  logic [127:0]           out_src;
  logic [9:0]             out_rd;
  logic [1:0]             out_rd_we;

  modport slave (
    input  flush, in_valid, in_pc, in_payload, in_src_en, in_src_addr, in_rd, in_rd_we,
    output in_ready,
    output reg1_read_en, reg2_read_en, reg1_read_addr1, reg1_read_addr2,
           reg2_read_addr1, reg2_read_addr2,
    input  reg1_read_data1, reg1_read_data2, reg2_read_data1, reg2_read_data2,
    input  fwd_valid, fwd_addr, fwd_data, fwd_ready,
    output out_valid, out_pc, out_payload, out_src, out_rd, out_rd_we,
    input  out_ready
  );

  modport master (
    output flush, in_valid, in_pc, in_payload, in_src_en, in_src_addr, in_rd, in_rd_we,
    input  in_ready,
    input  reg1_read_en, reg2_read_en, reg1_read_addr1, reg1_read_addr2,
           reg2_read_addr1, reg2_read_addr2,
    output reg1_read_data1, reg1_read_data2, reg2_read_data1, reg2_read_data2,
    output fwd_valid, fwd_addr, fwd_data, fwd_ready,
    input  out_valid, out_pc, out_payload, out_src, out_rd, out_rd_we,
    output out_ready
  );
endinterface

// File: rtl/dual_issue_dispatch.sv
// Dual-issue dispatch: buffers one decoded pair, resolves operands via regfile
// and forwarding, and issues 0/1/2 instructions in order into a registered EX port.
//
// state  | meaning
// EMPTY  | no buffered instruction
// PAIR   | freshly accepted pair in B0 (+B1 if lane1 valid)
// SINGLE | younger half of a split pair, moved into B0
module dual_issue_dispatch #(
  parameter int PAYLOAD_W = 64,
  parameter int FWD_N     = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  dual_issue_dispatch_if.slave bus
);

  typedef enum logic [1:0] {ST_EMPTY, ST_PAIR, ST_SINGLE} state_t;

  typedef struct packed {
    logic [31:0]          pc;
    logic [PAYLOAD_W-1:0] payload;
    logic [1:0]           src_en;
    logic [4:0]           src_a1;
    logic [4:0]           src_a2;
    logic [4:0]           rd;
    logic                 rd_we;
  } slot_t;

  state_t state, state_nxt;
  logic   b1_v, b1_v_nxt;
  slot_t  b0, b1, lane0_in, lane1_in;
  logic   b0_v;
  logic   can_load, issue0, issue1, haz0, haz1, raw01, drain_all, accept, shift;
  logic [32:0] r0a, r0b, r1a, r1b;

  // Result bit 32 flags a load-use hazard; lowest fwd index wins.
  function automatic logic [32:0] resolve(
    input logic                  en,
    input logic [4:0]            addr,
    input logic [31:0]           rf,
    input logic [FWD_N-1:0]      fv,
    input logic [5*FWD_N-1:0]    fa,
    input logic [32*FWD_N-1:0]   fd,
    input logic [FWD_N-1:0]      fr
  );
    logic        hit;
    logic        haz;
    logic [31:0] d;
    hit = 1'b0;
    haz = 1'b0;
    d   = rf;
    if (en && addr != 5'd0) begin
      for (int i = 0; i < FWD_N; i++) begin
        if (!hit && fv[i] && fa[i*5 +: 5] == addr) begin
          hit = 1'b1;
          haz = !fr[i];
          d   = fd[i*32 +: 32];
        end
      end
    end else begin
      d = 32'h0;
    end
    return {haz, d};
  endfunction

  always_comb begin
    lane0_in.pc      = bus.in_pc[31:0];
    lane0_in.payload = bus.in_payload[PAYLOAD_W-1:0];
    lane0_in.src_en  = bus.in_src_en[1:0];
    lane0_in.src_a1  = bus.in_src_addr[4:0];
    lane0_in.src_a2  = bus.in_src_addr[9:5];
    lane0_in.rd      = bus.in_rd[4:0];
    lane0_in.rd_we   = bus.in_rd_we[0];
    lane1_in.pc      = bus.in_pc[63:32];
    lane1_in.payload = bus.in_payload[2*PAYLOAD_W-1:PAYLOAD_W];
    lane1_in.src_en  = bus.in_src_en[3:2];
    lane1_in.src_a1  = bus.in_src_addr[14:10];
    lane1_in.src_a2  = bus.in_src_addr[19:15];
    lane1_in.rd      = bus.in_rd[9:5];
    lane1_in.rd_we   = bus.in_rd_we[1];
  end

  assign b0_v = (state != ST_EMPTY);

  assign bus.reg1_read_en    = b0_v ? b0.src_en : 2'b00;
  assign bus.reg2_read_en    = b1_v ? b1.src_en : 2'b00;
  assign bus.reg1_read_addr1 = b0.src_a1;
  assign bus.reg1_read_addr2 = b0.src_a2;
  assign bus.reg2_read_addr1 = b1.src_a1;
  assign bus.reg2_read_addr2 = b1.src_a2;

  assign r0a = resolve(b0.src_en[0], b0.src_a1, bus.reg1_read_data1,
                       bus.fwd_valid, bus.fwd_addr, bus.fwd_data, bus.fwd_ready);
  assign r0b = resolve(b0.src_en[1], b0.src_a2, bus.reg1_read_data2,
                       bus.fwd_valid, bus.fwd_addr, bus.fwd_data, bus.fwd_ready);
  assign r1a = resolve(b1.src_en[0], b1.src_a1, bus.reg2_read_data1,
                       bus.fwd_valid, bus.fwd_addr, bus.fwd_data, bus.fwd_ready);
  assign r1b = resolve(b1.src_en[1], b1.src_a2, bus.reg2_read_data2,
                       bus.fwd_valid, bus.fwd_addr, bus.fwd_data, bus.fwd_ready);

  assign haz0 = r0a[32] | r0b[32];
  assign haz1 = r1a[32] | r1b[32];

  // B1 reading B0's destination must wait for B0's result on the forwarding path.
  assign raw01 = b0.rd_we && (b0.rd != 5'd0) &&
                 ((b1.src_en[0] && b1.src_a1 == b0.rd) ||
                  (b1.src_en[1] && b1.src_a2 == b0.rd));

  assign can_load  = bus.out_ready || (bus.out_valid == 2'b00);
  assign issue0    = can_load && !bus.flush && b0_v && !haz0;
  assign issue1    = issue0 && b1_v && !haz1 && !raw01;
  assign drain_all = issue0 && (!b1_v || issue1);
  assign bus.in_ready = !bus.flush && ((state == ST_EMPTY) || drain_all);
  assign accept    = bus.in_ready && (bus.in_valid != 2'b00);
  assign shift     = issue0 && b1_v && !issue1;

  always_comb begin
    state_nxt = state;
    b1_v_nxt  = b1_v;
    if (bus.flush) begin
      state_nxt = ST_EMPTY;
      b1_v_nxt  = 1'b0;
    end else if (accept) begin
      state_nxt = ST_PAIR;
      b1_v_nxt  = bus.in_valid[1];
    end else if (shift) begin
      state_nxt = ST_SINGLE;
      b1_v_nxt  = 1'b0;
    end else if (issue0) begin
      state_nxt = ST_EMPTY;
      b1_v_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      b1_v  <= 1'b0;
    end else begin
      state <= state_nxt;
      b1_v  <= b1_v_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b0 <= '0;
      b1 <= '0;
    end else if (!bus.flush) begin
      if (accept) begin
        b0 <= lane0_in;
        b1 <= lane1_in;
      end else if (shift) begin
        b0 <= b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 2'b00;
      bus.out_pc      <= '0;
      bus.out_payload <= '0;
      bus.out_src     <= '0;
      bus.out_rd      <= '0;
      bus.out_rd_we   <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 2'b00;
    end else if (can_load) begin
      bus.out_valid <= {issue1, issue0};
      if (issue0) begin
        bus.out_pc[31:0]                <= b0.pc;
        bus.out_payload[PAYLOAD_W-1:0]  <= b0.payload;
        bus.out_src[63:0]               <= {r0b[31:0], r0a[31:0]};
        bus.out_rd[4:0]                 <= b0.rd;
        bus.out_rd_we[0]                <= b0.rd_we;
      end
      if (issue1) begin
        bus.out_pc[63:32]                        <= b1.pc;
        bus.out_payload[2*PAYLOAD_W-1:PAYLOAD_W] <= b1.payload;
        bus.out_src[127:64]                      <= {r1b[31:0], r1a[31:0]};
        bus.out_rd[9:5]                          <= b1.rd;
        bus.out_rd_we[1]                         <= b1.rd_we;
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_dispatch.sv
// Directed bench for dual_issue_dispatch with hand-computed expectations.
module tb_dual_issue_dispatch;
  localparam int PW = 64;
  localparam int FN = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] rf [32];

  dual_issue_dispatch_if #(.PAYLOAD_W(PW), .FWD_N(FN)) bus ();

  dual_issue_dispatch #(.PAYLOAD_W(PW), .FWD_N(FN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.reg1_read_data1 = rf[bus.reg1_read_addr1];
  assign bus.reg1_read_data2 = rf[bus.reg1_read_addr2];
  assign bus.reg2_read_data1 = rf[bus.reg2_read_addr1];
  assign bus.reg2_read_data2 = rf[bus.reg2_read_addr2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [3:0] en, input logic [19:0] a,
                       input logic [9:0] rd, input logic [1:0] we);
    bus.in_valid    = v;
    bus.in_pc       = {pc1, pc0};
    bus.in_payload  = {32'hBEEF0001, pc1, 32'hBEEF0000, pc0};
    bus.in_src_en   = en;
    bus.in_src_addr = a;
    bus.in_rd       = rd;
    bus.in_rd_we    = we;
  endtask

  task automatic set_fwd(input int i, input logic [4:0] a, input logic [31:0] d, input logic rdy);
    bus.fwd_valid[i]         = 1'b1;
    bus.fwd_addr[i*5 +: 5]   = a;
    bus.fwd_data[i*32 +: 32] = d;
    bus.fwd_ready[i]         = rdy;
  endtask

  task automatic clr_fwd();
    bus.fwd_valid = '0;
    bus.fwd_addr  = '0;
    bus.fwd_data  = '0;
    bus.fwd_ready = '1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[2] = 32'd5;
    rf[3] = 32'd7;
    rf[5] = 32'h55;
    rf[7] = 32'h77;
    rf[8] = 32'h88;
    rf[9] = 32'h99;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    offer(2'b00, 32'h0, 32'h0, 4'h0, 20'h0, 10'h0, 2'b00);
    clr_fwd();

    // reset
    #1 rst_n = 1'b0;
    step();
    step();
    chk("rst_out_valid", 128'(bus.out_valid), 128'h0);
    chk("rst_out_pc",    128'(bus.out_pc), 128'h0);
    chk("rst_out_src",   bus.out_src, 128'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  128'(bus.in_ready), 128'h1);
    step();

    // independent pair, then back-to-back second pair
    offer(2'b11, 32'h100, 32'h104, 4'b0111, {5'd0, 5'd5, 5'd3, 5'd2}, {5'd4, 5'd1}, 2'b11);
    #1 chk("ind_in_ready0", 128'(bus.in_ready), 128'h1);
    step();
    offer(2'b11, 32'h108, 32'h10C, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd7}, {5'd11, 5'd10}, 2'b11);
    #1 chk("ind_in_ready1", 128'(bus.in_ready), 128'h1);
    chk("ind_latency",   128'(bus.out_valid), 128'h0);
    step();
    bus.in_valid = 2'b00;
    chk("ind_valid",     128'(bus.out_valid), 128'h3);
    chk("ind_src",       bus.out_src, {32'h0, 32'h55, 32'd7, 32'd5});
    chk("ind_pc",        128'(bus.out_pc), 128'({32'h104, 32'h100}));
    chk("ind_rd",        128'({bus.out_rd_we, bus.out_rd}), 128'({2'b11, 5'd4, 5'd1}));
    chk("ind_payload",   bus.out_payload, {32'hBEEF0001, 32'h104, 32'hBEEF0000, 32'h100});
    step();
    chk("b2b_valid",     128'(bus.out_valid), 128'h3);
    chk("b2b_src0",      128'(bus.out_src[31:0]), 128'h77);
    chk("b2b_pc",        128'(bus.out_pc), 128'({32'h10C, 32'h108}));
    step();
    chk("empty_bubble",  128'(bus.out_valid), 128'h0);

    // intra-pair RAW on r6
    offer(2'b11, 32'h200, 32'h204, 4'b0101, {5'd0, 5'd6, 5'd0, 5'd2}, {5'd12, 5'd6}, 2'b11);
    step();
    bus.in_valid = 2'b00;
    chk("raw_in_ready",  128'(bus.in_ready), 128'h0);
    step();
    chk("raw_c1_valid",  128'(bus.out_valid), 128'h1);
    chk("raw_c1_pc",     128'(bus.out_pc[31:0]), 128'h200);
    chk("raw_c1_src",    128'(bus.out_src[31:0]), 128'd5);
    set_fwd(1, 5'd6, 32'h666, 1'b1);
    #1 chk("raw_c2_ready", 128'(bus.in_ready), 128'h1);
    step();
    chk("raw_c2_valid",  128'(bus.out_valid), 128'h1);
    chk("raw_c2_pc",     128'(bus.out_pc[31:0]), 128'h204);
    chk("raw_c2_src",    128'(bus.out_src[31:0]), 128'h666);
    chk("raw_c2_rd",     128'(bus.out_rd[4:0]), 128'd12);
    clr_fwd();

    // load-use on r8
    set_fwd(1, 5'd8, 32'h1234, 1'b0);
    offer(2'b01, 32'h300, 32'h0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd8}, {5'd0, 5'd13}, 2'b01);
    step();
    bus.in_valid = 2'b00;
    chk("lu_in_ready",   128'(bus.in_ready), 128'h0);
    step();
    chk("lu_bubble",     128'(bus.out_valid), 128'h0);
    clr_fwd();
    set_fwd(3, 5'd8, 32'hDEADBEEF, 1'b1);
    step();
    chk("lu_valid",      128'(bus.out_valid), 128'h1);
    chk("lu_src",        128'(bus.out_src[31:0]), 128'hDEADBEEF);
    clr_fwd();

    // priority and r0
    set_fwd(0, 5'd9, 32'd11, 1'b1);
    set_fwd(4, 5'd9, 32'd22, 1'b1);
    set_fwd(2, 5'd0, 32'hFF, 1'b0);
    offer(2'b01, 32'h400, 32'h0, 4'b0011, {5'd0, 5'd0, 5'd0, 5'd9}, {5'd0, 5'd14}, 2'b01);
    step();
    bus.in_valid = 2'b00;
    step();
    chk("prio_valid",    128'(bus.out_valid), 128'h1);
    chk("prio_src",      128'(bus.out_src[63:0]), 128'({32'h0, 32'd11}));
    clr_fwd();

    // backpressure
    bus.out_ready = 1'b0;
    offer(2'b11, 32'h500, 32'h504, 4'b0000, 20'h0, 10'h0, 2'b00);
    step();
    bus.in_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid",    128'(bus.out_valid), 128'h1);
      chk("bp_pc",       128'(bus.out_pc[31:0]), 128'h400);
      chk("bp_in_ready", 128'(bus.in_ready), 128'h0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_release",    128'(bus.out_valid), 128'h3);
    chk("bp_rel_pc",     128'(bus.out_pc), 128'({32'h504, 32'h500}));

    // flush during SINGLE
    offer(2'b11, 32'h600, 32'h604, 4'b0101, {5'd0, 5'd6, 5'd0, 5'd2}, {5'd12, 5'd6}, 2'b11);
    step();
    bus.in_valid = 2'b00;
    step();
    chk("fl_single",     128'(bus.out_pc[31:0]), 128'h600);
    bus.flush = 1'b1;
    offer(2'b01, 32'h700, 32'h0, 4'b0000, 20'h0, 10'h0, 2'b00);
    #1 chk("fl_in_ready", 128'(bus.in_ready), 128'h0);
    step();
    bus.flush = 1'b0;
    bus.in_valid = 2'b00;
    chk("fl_valid",      128'(bus.out_valid), 128'h0);
    #1 chk("fl_empty",   128'(bus.in_ready), 128'h1);
    step();
    chk("fl_discard",    128'(bus.out_valid), 128'h0);

    // async reset mid-cycle
    offer(2'b11, 32'h800, 32'h804, 4'b0000, 20'h0, 10'h0, 2'b00);
    step();
    bus.in_valid = 2'b00;
    step();
    chk("ar_before",     128'(bus.out_valid), 128'h3);
    #2 rst_n = 1'b0;
    #1 chk("ar_valid",   128'(bus.out_valid), 128'h0);
    chk("ar_pc",         128'(bus.out_pc), 128'h0);
    rst_n = 1'b1;
    #1 chk("ar_in_ready", 128'(bus.in_ready), 128'h1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
